// File: rtl/mem_io_pkg.sv
// Shared types and constants for the CPU memory/I-O controller.
package mem_io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  localparam logic [15:0] IO_SWITCH_ADDR      = 16'hFFFF;
  localparam logic [15:0] IO_CYCLE_ADDR       = 16'hFFFE;
  localparam int          WAIT_CYCLES_DEFAULT = 2;
  localparam int          WAIT_CNT_W          = 4;

  function automatic logic isIoAddr(input logic [15:0] addr);
    return (addr == IO_SWITCH_ADDR) || (addr == IO_CYCLE_ADDR);
  endfunction

endpackage

// File: rtl/io_regs.sv
// Memory-mapped I/O registers: hex display latch, free-running cycle counter,
// and the read mux that selects switches or counter by address.
module io_regs
  import mem_io_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] rdAddr_i,
  input  logic [15:0] switches_i,
  input  logic        hexWe_i,
  input  logic [15:0] hexData_i,
  output logic [15:0] hexOut_o,
  output logic [15:0] rdData_o
);

  logic [15:0] hex_q;
  logic [15:0] cycleCnt_q;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      hex_q      <= 16'h0000;
      cycleCnt_q <= 16'h0000;
    end else begin
      cycleCnt_q <= cycleCnt_q + 16'd1;
      if (hexWe_i) hex_q <= hexData_i;
    end
  end

  assign hexOut_o = hex_q;
  assign rdData_o = (rdAddr_i == IO_SWITCH_ADDR) ? switches_i : cycleCnt_q;

endmodule

// File: rtl/memory_io_ctrl.sv
// CPU-side memory controller: SRAM accesses with a fixed wait count, plus
// two memory-mapped I/O locations at the top of the address space.
module memory_io_ctrl
  import mem_io_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MIO_EN,
  input  logic        R_W,
  input  logic [15:0] Address,
  input  logic [15:0] Data_From_CPU,
  output logic [15:0] Data_To_CPU,
  output logic        R,
  input  logic [15:0] Switches,
  output logic [15:0] Hex_Out,
  output logic [15:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_OUT,
  input  logic [15:0] SRAM_DQ_IN,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N
);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] waitCnt_q, waitCnt_d;
  logic [15:0]           rdData_q, rdData_d;
  logic                  hexWe_q, hexWe_d;
  logic [15:0]           hexData_q, hexData_d;
  logic [15:0]           ioRdData;

  io_regs u_io_regs (
    .Clk        (Clk),
    .Reset      (Reset),
    .rdAddr_i   (Address),
    .switches_i (Switches),
    .hexWe_i    (hexWe_q),
    .hexData_i  (hexData_q),
    .hexOut_o   (Hex_Out),
    .rdData_o   (ioRdData)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
      rdData_q  <= 16'h0000;
      hexWe_q   <= 1'b0;
      hexData_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      rdData_q  <= rdData_d;
      hexWe_q   <= hexWe_d;
      hexData_q <= hexData_d;
    end
  end

  // The hex write is latched on entry to DONE so it commits even if the CPU
  // drops MIO_EN or moves the address during the ready cycle.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    rdData_d  = rdData_q;
    hexWe_d   = 1'b0;
    hexData_d = hexData_q;
    case (state_q)
      IDLE: begin
        if (MIO_EN) begin
          if (isIoAddr(Address)) begin
            state_d   = DONE;
            hexWe_d   = R_W && (Address == IO_SWITCH_ADDR);
            hexData_d = Data_From_CPU;
            if (!R_W) rdData_d = ioRdData;
          end else begin
            state_d   = ACCESS;
            waitCnt_d = WAIT_CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      ACCESS: begin
        if (!MIO_EN) begin
          state_d = IDLE;
        end else if (waitCnt_q == '0) begin
          state_d = DONE;
          if (!R_W) rdData_d = SRAM_DQ_IN;
        end else begin
          waitCnt_d = waitCnt_q - WAIT_CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    SRAM_CE_N   = 1'b1;
    SRAM_OE_N   = 1'b1;
    SRAM_WE_N   = 1'b1;
    SRAM_ADDR   = 16'h0000;
    SRAM_DQ_OUT = 16'h0000;
    if (state_q == ACCESS) begin
      SRAM_CE_N = 1'b0;
      SRAM_ADDR = Address;
      if (R_W) begin
        SRAM_WE_N   = 1'b0;
        SRAM_DQ_OUT = Data_From_CPU;
      end else begin
        SRAM_OE_N = 1'b0;
      end
    end
  end

  assign R           = (state_q == DONE);
  assign Data_To_CPU = rdData_q;

endmodule

// File: tb/tb_memory_io_ctrl.sv
// Scoreboard bench for memory_io_ctrl with a behavioural SRAM and cycle model.
module tb_memory_io_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        MIO_EN;
  logic        R_W;
  logic [15:0] Address;
  logic [15:0] Data_From_CPU;
  logic [15:0] Data_To_CPU;
  logic        R;
  logic [15:0] Switches;
  logic [15:0] Hex_Out;
  logic [15:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_OUT;
  logic [15:0] SRAM_DQ_IN;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;
  logic        SRAM_WE_N;

  logic [15:0] sramMem [0:65535];
  logic [15:0] tbCyc;
  logic [15:0] expQ [$];
  int          passCnt = 0;
  int          checkCnt = 0;

  always #5 Clk = ~Clk;

  memory_io_ctrl #(.WAIT_CYCLES(2)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .MIO_EN        (MIO_EN),
    .R_W           (R_W),
    .Address       (Address),
    .Data_From_CPU (Data_From_CPU),
    .Data_To_CPU   (Data_To_CPU),
    .R             (R),
    .Switches      (Switches),
    .Hex_Out       (Hex_Out),
    .SRAM_ADDR     (SRAM_ADDR),
    .SRAM_DQ_OUT   (SRAM_DQ_OUT),
    .SRAM_DQ_IN    (SRAM_DQ_IN),
    .SRAM_CE_N     (SRAM_CE_N),
    .SRAM_OE_N     (SRAM_OE_N),
    .SRAM_WE_N     (SRAM_WE_N)
  );

  // Asynchronous-read, edge-written SRAM seen through the active-low strobes
  assign SRAM_DQ_IN = (!SRAM_CE_N && !SRAM_OE_N) ? sramMem[SRAM_ADDR] : 16'h0000;

  always @(posedge Clk) begin
    if (!SRAM_CE_N && !SRAM_WE_N) sramMem[SRAM_ADDR] <= SRAM_DQ_OUT;
  end

  always @(posedge Clk) begin
    if (!Reset) tbCyc <= 16'h0000;
    else        tbCyc <= tbCyc + 16'd1;
  end

  // Drives one CPU request and waits for R; expKind 1 pushes expVal, 2 pushes
  // the cycle count expected at the sampling edge, 0 pushes nothing.
  task automatic cpuAccess(input logic rw, input logic [15:0] addr, input logic [15:0] wdata,
                           input int expKind, input logic [15:0] expVal, input int skip,
                           output int lat, output int oeCyc, output int weCyc, output int busBad);
    @(negedge Clk);
    MIO_EN        = 1'b1;
    R_W           = rw;
    Address       = addr;
    Data_From_CPU = wdata;
    if (expKind == 1) expQ.push_back(expVal);
    else if (expKind == 2) expQ.push_back(tbCyc + 16'(skip));
    lat    = -1;
    oeCyc  = 0;
    weCyc  = 0;
    busBad = 0;
    repeat (skip) @(posedge Clk);
    for (int n = 1; n <= 40; n++) begin
      @(posedge Clk);
      #1;
      if (R) begin
        lat = n;
        break;
      end
      if (!SRAM_CE_N && !SRAM_OE_N) oeCyc++;
      if (!SRAM_CE_N && !SRAM_WE_N) begin
        weCyc++;
        if (SRAM_DQ_OUT !== wdata) busBad++;
      end
      if (!SRAM_CE_N && SRAM_ADDR !== addr) busBad++;
    end
  endtask

  task automatic endAccess();
    @(negedge Clk);
    MIO_EN        = 1'b0;
    R_W           = 1'b0;
    Address       = 16'h0000;
    Data_From_CPU = 16'h0000;
  endtask

  task automatic test_reset();
    int lat, oe, we, bad;
    logic [15:0] e;
    repeat (2) @(posedge Clk);
    #1;
    checkCnt++; if (R !== 1'b0) $display("[TB] FAIL rst_R: got %b expected 0", R); else passCnt++;
    checkCnt++; if (Data_To_CPU !== 16'h0) $display("[TB] FAIL rst_data: got %h expected 0000", Data_To_CPU); else passCnt++;
    checkCnt++; if (Hex_Out !== 16'h0) $display("[TB] FAIL rst_hex: got %h expected 0000", Hex_Out); else passCnt++;
    checkCnt++; if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N} !== 3'b111) $display("[TB] FAIL rst_strobes: got %b expected 111", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}); else passCnt++;
    checkCnt++; if ({SRAM_ADDR, SRAM_DQ_OUT} !== 32'h0) $display("[TB] FAIL rst_bus: got %h expected 00000000", {SRAM_ADDR, SRAM_DQ_OUT}); else passCnt++;
    @(negedge Clk);
    Reset = 1'b1;
    // One edge after release the counter reads 1, then 3 after a back-to-back read
    cpuAccess(1'b0, 16'hFFFE, 16'h0, 1, 16'd1, 0, lat, oe, we, bad);
    e = (expQ.size() > 0) ? expQ.pop_front() : 16'hDEAD;
    checkCnt++; if (Data_To_CPU !== e) $display("[TB] FAIL rst_cyc0: got %h expected %h", Data_To_CPU, e); else passCnt++;
    cpuAccess(1'b0, 16'hFFFE, 16'h0, 1, 16'd3, 1, lat, oe, we, bad);
    e = (expQ.size() > 0) ? expQ.pop_front() : 16'hDEAD;
    checkCnt++; if (Data_To_CPU !== e) $display("[TB] FAIL rst_cyc1: got %h expected %h", Data_To_CPU, e); else passCnt++;
    endAccess();
  endtask

  task automatic test_sram_read();
    int lat, oe, we, bad;
    logic [15:0] e;
    cpuAccess(1'b0, 16'h3000, 16'h0, 1, 16'h1234, 0, lat, oe, we, bad);
    checkCnt++; if (lat !== 3) $display("[TB] FAIL rd_latency: got %0d expected 3", lat); else passCnt++;
    checkCnt++; if (oe !== 2 || we !== 0) $display("[TB] FAIL rd_strobes: got oe=%0d we=%0d expected oe=2 we=0", oe, we); else passCnt++;
    checkCnt++; if (bad !== 0) $display("[TB] FAIL rd_bus: got %0d bad cycles expected 0", bad); else passCnt++;
    e = (expQ.size() > 0) ? expQ.pop_front() : 16'hDEAD;
    checkCnt++; if (Data_To_CPU !== e) $display("[TB] FAIL rd_data: got %h expected %h", Data_To_CPU, e); else passCnt++;
    endAccess();
    @(posedge Clk);
    #1;
    checkCnt++; if (R !== 1'b0) $display("[TB] FAIL rd_R_pulse: got %b expected 0", R); else passCnt++;
  endtask

  task automatic test_sram_write();
    int lat, oe, we, bad;
    logic [15:0] e;
    cpuAccess(1'b1, 16'h0010, 16'hBEEF, 0, 16'h0, 0, lat, oe, we, bad);
    checkCnt++; if (lat !== 3) $display("[TB] FAIL wr_latency: got %0d expected 3", lat); else passCnt++;
    checkCnt++; if (we !== 2 || oe !== 0) $display("[TB] FAIL wr_strobes: got we=%0d oe=%0d expected we=2 oe=0", we, oe); else passCnt++;
    checkCnt++; if (bad !== 0) $display("[TB] FAIL wr_bus: got %0d bad cycles expected 0", bad); else passCnt++;
    checkCnt++; if (Data_To_CPU !== 16'h1234) $display("[TB] FAIL wr_data_hold: got %h expected 1234", Data_To_CPU); else passCnt++;
    endAccess();
    cpuAccess(1'b0, 16'h0010, 16'h0, 1, 16'hBEEF, 0, lat, oe, we, bad);
    e = (expQ.size() > 0) ? expQ.pop_front() : 16'hDEAD;
    checkCnt++; if (Data_To_CPU !== e) $display("[TB] FAIL wr_readback: got %h expected %h", Data_To_CPU, e); else passCnt++;
    endAccess();
  endtask

  task automatic test_io();
    int lat, oe, we, bad;
    logic [15:0] e;
    Switches = 16'h00A5;
    cpuAccess(1'b0, 16'hFFFF, 16'h0, 1, 16'h00A5, 0, lat, oe, we, bad);
    checkCnt++; if (lat !== 1) $display("[TB] FAIL io_rd_latency: got %0d expected 1", lat); else passCnt++;
    e = (expQ.size() > 0) ? expQ.pop_front() : 16'hDEAD;
    checkCnt++; if (Data_To_CPU !== e) $display("[TB] FAIL io_rd_sw: got %h expected %h", Data_To_CPU, e); else passCnt++;
    endAccess();
    // endAccess drops MIO_EN in the ready cycle; the write must still land
    cpuAccess(1'b1, 16'hFFFF, 16'h0C3F, 0, 16'h0, 0, lat, oe, we, bad);
    checkCnt++; if (lat !== 1) $display("[TB] FAIL io_wr_latency: got %0d expected 1", lat); else passCnt++;
    endAccess();
    @(posedge Clk);
    #1;
    checkCnt++; if (Hex_Out !== 16'h0C3F) $display("[TB] FAIL io_hex: got %h expected 0C3F", Hex_Out); else passCnt++;
    cpuAccess(1'b1, 16'hFFFE, 16'h1111, 0, 16'h0, 0, lat, oe, we, bad);
    checkCnt++; if (lat !== 1) $display("[TB] FAIL io_wr_cyc_latency: got %0d expected 1", lat); else passCnt++;
    endAccess();
    @(posedge Clk);
    #1;
    checkCnt++; if (Hex_Out !== 16'h0C3F) $display("[TB] FAIL io_hex_hold: got %h expected 0C3F", Hex_Out); else passCnt++;
    checkCnt++; if (Data_To_CPU !== 16'h00A5) $display("[TB] FAIL io_data_hold: got %h expected 00A5", Data_To_CPU); else passCnt++;
  endtask

  task automatic test_abort();
    int rSeen;
    @(negedge Clk);
    MIO_EN  = 1'b1;
    R_W     = 1'b0;
    Address = 16'h3000;
    @(posedge Clk);
    #1;
    checkCnt++; if (SRAM_CE_N !== 1'b0) $display("[TB] FAIL ab_access: got CE_N=%b expected 0", SRAM_CE_N); else passCnt++;
    @(negedge Clk);
    MIO_EN = 1'b0;
    @(posedge Clk);
    #1;
    checkCnt++; if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N} !== 3'b111) $display("[TB] FAIL ab_strobes: got %b expected 111", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}); else passCnt++;
    rSeen = (R === 1'b1) ? 1 : 0;
    repeat (5) begin
      @(posedge Clk);
      #1;
      if (R === 1'b1) rSeen++;
    end
    checkCnt++; if (rSeen !== 0) $display("[TB] FAIL ab_noR: got %0d R cycles expected 0", rSeen); else passCnt++;
    checkCnt++; if (Data_To_CPU !== 16'h00A5) $display("[TB] FAIL ab_data: got %h expected 00A5", Data_To_CPU); else passCnt++;
  endtask

  task automatic test_reset_mid();
    int rSeen;
    @(negedge Clk);
    MIO_EN  = 1'b1;
    R_W     = 1'b0;
    Address = 16'h3000;
    @(posedge Clk);
    @(negedge Clk);
    Reset  = 1'b0;
    MIO_EN = 1'b0;
    @(posedge Clk);
    #1;
    checkCnt++; if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N} !== 3'b111) $display("[TB] FAIL rm_strobes: got %b expected 111", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}); else passCnt++;
    checkCnt++; if (Data_To_CPU !== 16'h0 || Hex_Out !== 16'h0) $display("[TB] FAIL rm_regs: got data=%h hex=%h expected 0000", Data_To_CPU, Hex_Out); else passCnt++;
    rSeen = (R === 1'b1) ? 1 : 0;
    @(negedge Clk);
    Reset = 1'b1;
    repeat (4) begin
      @(posedge Clk);
      #1;
      if (R === 1'b1) rSeen++;
    end
    checkCnt++; if (rSeen !== 0) $display("[TB] FAIL rm_noR: got %0d R cycles expected 0", rSeen); else passCnt++;
  endtask

  task automatic test_back_to_back();
    int lat, oe, we, bad;
    logic [15:0] e;
    cpuAccess(1'b0, 16'h0010, 16'h0, 1, 16'hBEEF, 0, lat, oe, we, bad);
    e = (expQ.size() > 0) ? expQ.pop_front() : 16'hDEAD;
    checkCnt++; if (lat !== 3 || Data_To_CPU !== e) $display("[TB] FAIL b2b_first: got lat=%0d data=%h expected lat=3 data=%h", lat, Data_To_CPU, e); else passCnt++;
    cpuAccess(1'b0, 16'h3000, 16'h0, 1, 16'h1234, 1, lat, oe, we, bad);
    e = (expQ.size() > 0) ? expQ.pop_front() : 16'hDEAD;
    checkCnt++; if (lat !== 3 || Data_To_CPU !== e) $display("[TB] FAIL b2b_second: got lat=%0d data=%h expected lat=3 data=%h", lat, Data_To_CPU, e); else passCnt++;
    endAccess();
  endtask

  task automatic test_wrap();
    int lat, oe, we, bad;
    logic [15:0] e;
    for (int i = 0; i < 70000 && tbCyc !== 16'hFFFE; i++) @(negedge Clk);
    if (tbCyc !== 16'hFFFE) begin
      checkCnt++;
      $display("[TB] FAIL wrap_wait: got %h expected FFFE", tbCyc);
    end
    cpuAccess(1'b0, 16'hFFFE, 16'h0, 1, 16'hFFFF, 0, lat, oe, we, bad);
    e = (expQ.size() > 0) ? expQ.pop_front() : 16'hDEAD;
    checkCnt++; if (Data_To_CPU !== e) $display("[TB] FAIL wrap_top: got %h expected %h", Data_To_CPU, e); else passCnt++;
    cpuAccess(1'b0, 16'hFFFE, 16'h0, 1, 16'h0001, 1, lat, oe, we, bad);
    e = (expQ.size() > 0) ? expQ.pop_front() : 16'hDEAD;
    checkCnt++; if (lat !== 1 || Data_To_CPU !== e) $display("[TB] FAIL wrap_after: got lat=%0d data=%h expected lat=1 data=%h", lat, Data_To_CPU, e); else passCnt++;
    endAccess();
  endtask

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset         = 1'b0;
    MIO_EN        = 1'b0;
    R_W           = 1'b0;
    Address       = 16'h0000;
    Data_From_CPU = 16'h0000;
    Switches      = 16'h0000;
    for (int i = 0; i < 65536; i++) sramMem[i] = 16'h0000;
    sramMem[16'h3000] = 16'h1234;
    test_reset();
    test_sram_read();
    test_sram_write();
    test_io();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
